stack_arbiter: RTL
==================

STACK_ARBITER -- requirements
Module: stack_arbiter

Interface
REQ-001 SHALL have parameter WIDTH_DATA, default 16, meaning the width of a stack word, matching the shared stack instance.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 SHALL have ports req0/req1, input, 1 bit each: requester 0/1 asks for one stack operation; held until ack.
REQ-005 SHALL have ports op0/op1, input, 1 bit each: 1 = push, 0 = pop; held stable while req high.
REQ-006 SHALL have ports wdata0/wdata1, input, WIDTH_DATA each: push data; held stable while req high.
REQ-007 SHALL have ports ack0/ack1, output, 1 bit each: one-cycle completion pulse to requester 0/1.
REQ-008 SHALL have ports err0/err1, output, 1 bit each: valid only with ack; 1 = operation rejected (push when full, pop when empty).
REQ-009 SHALL have port rdata, output, WIDTH_DATA: popped word; valid in the ack cycle of a successful pop.
REQ-010 SHALL have port gnt, output, 2 bits: one-hot owner of the stack from the ISSUE cycle through the DONE cycle; 00 otherwise.
REQ-011 SHALL have ports stk_push and stk_pop, output, 1 bit each: drive the stack's push and pop inputs.
REQ-012 SHALL have port stk_data_in, output, WIDTH_DATA: drives the stack's data_in.
REQ-013 SHALL have ports stk_full, stk_empty and stk_data_out, inputs of 1, 1 and WIDTH_DATA bits: taken from the stack.
REQ-014 SHALL treat the stack as follows: it applies push or pop at the clk edge where that input is high; data_out is registered and valid the cycle after pop; full and empty reflect the pointer after that edge.

Function
REQ-015 SHALL implement the FSM states IDLE, ISSUE, CAPTURE and DONE.
REQ-016 In IDLE with any req high, SHALL select a winner by round-robin: the requester not granted last wins a tie; a single requester wins outright.
REQ-017 In IDLE, SHALL latch the winner's index, op and wdata.
REQ-018 In IDLE, SHALL check stk_full (for a push) or stk_empty (for a pop) in the same cycle.
REQ-019 On a legal request, IDLE SHALL go to ISSUE.
REQ-020 On an illegal request, IDLE SHALL go to DONE with err set; no stk_push or stk_pop is asserted; the round-robin pointer is still updated.
REQ-021 In ISSUE, SHALL assert exactly one of stk_push or stk_pop for exactly one cycle.
REQ-022 In ISSUE, stk_data_in SHALL equal the latched wdata.
REQ-023 From ISSUE, a push SHALL go to DONE and a pop SHALL go to CAPTURE.
REQ-024 In CAPTURE, SHALL register stk_data_out into rdata, then go to DONE.
REQ-025 In DONE, SHALL pulse the winner's ack (and err if rejected) for one cycle, update the last-granted pointer, then go to IDLE.
REQ-026 SHALL ignore req inputs in ISSUE, CAPTURE and DONE; there is no pre-emption.
REQ-027 Requesters SHALL drop req in the cycle after ack is seen; a req still high in IDLE is a new request.
REQ-028 Latency from IDLE sampling req to ack: push 2 cycles, pop 3 cycles, rejected operation 1 cycle.
REQ-029 stk_push and stk_pop SHALL never be high together and SHALL be 0 outside ISSUE.
REQ-030 ack0 and ack1 SHALL never be high together.
REQ-031 rdata SHALL hold its last captured value until the next CAPTURE; after a push or a rejected operation, rdata is don't-care.
REQ-032 Back-to-back operations SHALL follow stack order: push A, push B, pop, pop returns B then A.

Reset
REQ-033 Reset SHALL put the FSM in IDLE.
REQ-034 Reset SHALL clear ack0, ack1, err0, err1, gnt, stk_push, stk_pop, stk_data_in and rdata to 0.
REQ-035 Reset SHALL set the last-granted pointer to 1, so requester 0 wins the first tie.
REQ-036 Reset asserted mid-operation (in ISSUE, CAPTURE or DONE) SHALL abort the operation: no ack is issued and the FSM is in IDLE the next cycle; the stack is reset by the same signal.
REQ-037 Reset SHALL take priority over every other input.

Verification
REQ-038 Bench SHALL cover: after reset, req0 pushes 0x1234 -> stk_push high 1 cycle with stk_data_in=0x1234; ack0 2 cycles after req is sampled; err0=0.
REQ-039 Bench SHALL cover: req1 pops after that push -> stk_pop high 1 cycle; ack1 3 cycles after req is sampled; rdata=0x1234; err1=0.
REQ-040 Bench SHALL cover: req0 and req1 both push, held continuously -> grants alternate 0,1,0,1; stack order is confirmed by 4 pops.
REQ-041 Bench SHALL cover: pop on an empty stack -> ack with err=1 one cycle after req is sampled; stk_pop never asserted.
REQ-042 Bench SHALL cover: push on a full stack (stk_full=1) -> ack with err=1; stk_push never asserted; stack contents unchanged.
REQ-043 Bench SHALL cover: reset asserted in CAPTURE -> no ack; all outputs 0 next cycle; FSM in IDLE; the next tie is granted to requester 0.

Source files
------------

// File: rtl/stack_arbiter.sv
// Two-requester round-robin arbiter in front of a shared stack: one operation
// at a time, with full/empty rejection and a one-cycle ack/err handshake.
module stack_arbiter #(
    parameter int WIDTH_DATA = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  op0,
    input  logic                  op1,
    input  logic [WIDTH_DATA-1:0] wdata0,
    input  logic [WIDTH_DATA-1:0] wdata1,
    output logic                  ack0,
    output logic                  ack1,
    output logic                  err0,
    output logic                  err1,
    output logic [WIDTH_DATA-1:0] rdata,
    output logic [1:0]            gnt,
    output logic                  stk_push,
    output logic                  stk_pop,
    output logic [WIDTH_DATA-1:0] stk_data_in,
    input  logic                  stk_full,
    input  logic                  stk_empty,
    input  logic [WIDTH_DATA-1:0] stk_data_out
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        DONE
    } state_t;

    state_t                state;
    state_t                state_next;

    logic                  win;
    logic                  win_op;
    logic [WIDTH_DATA-1:0] win_data;
    logic                  win_err;
    logic                  last;

    logic                  sel;
    logic                  sel_op;
    logic [WIDTH_DATA-1:0] sel_data;
    logic                  sel_rej;
    logic                  any_req;

    // Requester not granted last wins a tie; a lone requester wins outright.
    always_comb begin
        any_req  = req0 | req1;
        sel      = (req0 && req1) ? ~last : req1;
        sel_op   = sel ? op1 : op0;
        sel_data = sel ? wdata1 : wdata0;
        sel_rej  = sel_op ? stk_full : stk_empty;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any_req) state_next = sel_rej ? DONE : ISSUE;
            ISSUE:   state_next = win_op ? DONE : CAPTURE;
            CAPTURE: state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            win      <= 1'b0;
            win_op   <= 1'b0;
            win_data <= '0;
            win_err  <= 1'b0;
            last     <= 1'b1;
            rdata    <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && any_req) begin
                win      <= sel;
                win_op   <= sel_op;
                win_data <= sel_data;
                win_err  <= sel_rej;
            end
            if (state == CAPTURE) rdata <= stk_data_out;
            if (state == DONE) last <= win;
        end
    end

    // Handshake and stack strobes are pure decodes of the FSM state, so they
    // are zero in IDLE and therefore zero straight out of reset.
    always_comb begin
        ack0        = (state == DONE) && !win;
        ack1        = (state == DONE) && win;
        err0        = ack0 && win_err;
        err1        = ack1 && win_err;
        gnt         = (state == IDLE) ? 2'b00 : {win, ~win};
        stk_push    = (state == ISSUE) && win_op;
        stk_pop     = (state == ISSUE) && !win_op;
        stk_data_in = (state == ISSUE) ? win_data : '0;
    end

endmodule
